sram_sp_arb2: RTL and testbench

Two-port round-robin arbiter that shares one single-port synchronous SRAM (1024 x 16, registered read data, `ME`/`WE` strobes) between two independent requesters, A and B. Each requester issues read or write requests through a valid/ready handshake and receives read data through a one-cycle-latency response strobe. The block sits between client logic and the SRAM macro and drives the macro's `ME`, `WE`, `ADR` and `D` pins directly.

---
 rtl/sram_sp_arb2.sv | 62 ++++++
 tb/tb_sram_sp_arb2.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_arb2.sv
// sram_sp_arb2: round-robin arbiter sharing one single-port synchronous SRAM
// between two valid/ready requesters, with one-cycle read responses per port.
module sram_sp_arb2 #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic          a_req_we,
    input  logic [AW-1:0] a_req_adr,
    input  logic [DW-1:0] a_req_wdata,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_rdata,
    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_req_we,
    input  logic [AW-1:0] b_req_adr,
    input  logic [DW-1:0] b_req_wdata,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_rdata,
    output logic          sram_me,
    output logic          sram_we,
    output logic [AW-1:0] sram_adr,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);
    logic          prio, rd_pend_a, rd_pend_b, gnt_a, gnt_b;
    logic [DW-1:0] a_hold, b_hold;

    // B only wins when A is idle or B holds the priority pointer
    assign gnt_a = ~rst & a_req_valid & (~b_req_valid | ~prio);
    assign gnt_b = ~rst & b_req_valid & ~gnt_a;

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;
    assign sram_me     = gnt_a | gnt_b;
    assign sram_we     = gnt_b ? b_req_we : gnt_a & a_req_we;
    assign sram_adr    = gnt_b ? b_req_adr : a_req_adr;
    assign sram_d      = gnt_b ? b_req_wdata : a_req_wdata;
    assign a_rsp_valid = rd_pend_a;
    assign b_rsp_valid = rd_pend_b;
    assign a_rsp_rdata = rd_pend_a ? sram_q : a_hold;
    assign b_rsp_rdata = rd_pend_b ? sram_q : b_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio      <= 1'b0;
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
            a_hold    <= '0;
            b_hold    <= '0;
        end else begin
            prio      <= gnt_a ? 1'b1 : gnt_b ? 1'b0 : prio;
            rd_pend_a <= gnt_a & ~a_req_we;
            rd_pend_b <= gnt_b & ~b_req_we;
            if (rd_pend_a) a_hold <= sram_q;
            if (rd_pend_b) b_hold <= sram_q;
        end
    end
endmodule

// File: tb/tb_sram_sp_arb2.sv
// tb_sram_sp_arb2: scoreboard bench with an SRAM macro model and a reference
// arbitration model checked every cycle on the falling edge.
module tb_sram_sp_arb2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req_valid = 1'b0, a_req_we = 1'b0, b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [9:0]  a_req_adr = '0, b_req_adr = '0;
    logic [15:0] a_req_wdata = '0, b_req_wdata = '0;
    logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [15:0] a_rsp_rdata, b_rsp_rdata;
    logic        sram_me, sram_we;
    logic [9:0]  sram_adr;
    logic [15:0] sram_d;
    logic [15:0] sram_q = '0;
    logic [15:0] mem [1024] = '{default: 16'h0};
    logic [15:0] ref_mem [1024] = '{default: 16'h0};
    logic [15:0] qa[$], qb[$];
    logic        m_prio = 1'b0, m_pa = 1'b0, m_pb = 1'b0;
    logic [15:0] m_ha = '0, m_hb = '0;
    int          checks = 0, failures = 0;
    int          cnt_ga = 0, cnt_gb = 0, cnt_ra = 0, cnt_rb = 0;

    sram_sp_arb2 dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_adr(a_req_adr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_adr(b_req_adr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .sram_me(sram_me), .sram_we(sram_we), .sram_adr(sram_adr),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_me) begin
            if (sram_we) mem[sram_adr] <= sram_d;
            else sram_q <= mem[sram_adr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: responses for the previous cycle, then this cycle's grant
    always @(negedge clk or posedge rst) begin
        logic ga, gb;
        if (rst) begin
            m_prio = 1'b0; m_pa = 1'b0; m_pb = 1'b0; m_ha = '0; m_hb = '0;
            qa.delete(); qb.delete();
        end else begin
            chk("a_rsp_valid", 32'(a_rsp_valid), 32'(m_pa));
            chk("b_rsp_valid", 32'(b_rsp_valid), 32'(m_pb));
            if (m_pa) begin
                if (qa.size() == 0) chk("a_queue_underflow", 32'(qa.size()), 1);
                else m_ha = qa.pop_front();
            end
            if (m_pb) begin
                if (qb.size() == 0) chk("b_queue_underflow", 32'(qb.size()), 1);
                else m_hb = qb.pop_front();
            end
            chk("a_rsp_rdata", 32'(a_rsp_rdata), 32'(m_ha));
            chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(m_hb));
            cnt_ra += int'(a_rsp_valid);
            cnt_rb += int'(b_rsp_valid);
            ga = a_req_valid & (~b_req_valid | ~m_prio);
            gb = b_req_valid & ~ga;
            chk("a_req_ready", 32'(a_req_ready), 32'(ga));
            chk("b_req_ready", 32'(b_req_ready), 32'(gb));
            chk("sram_me", 32'(sram_me), 32'(ga | gb));
            chk("sram_we", 32'(sram_we), 32'(ga ? a_req_we : gb & b_req_we));
            if (ga) begin
                chk("sram_adr_a", 32'(sram_adr), 32'(a_req_adr));
                if (a_req_we) begin
                    chk("sram_d_a", 32'(sram_d), 32'(a_req_wdata));
                    ref_mem[a_req_adr] = a_req_wdata;
                end else qa.push_back(ref_mem[a_req_adr]);
            end
            if (gb) begin
                chk("sram_adr_b", 32'(sram_adr), 32'(b_req_adr));
                if (b_req_we) begin
                    chk("sram_d_b", 32'(sram_d), 32'(b_req_wdata));
                    ref_mem[b_req_adr] = b_req_wdata;
                end else qb.push_back(ref_mem[b_req_adr]);
            end
            m_pa = ga & ~a_req_we;
            m_pb = gb & ~b_req_we;
            m_prio = ga ? 1'b1 : gb ? 1'b0 : m_prio;
            cnt_ga += int'(a_req_ready);
            cnt_gb += int'(b_req_ready);
        end
    end

    // Called just after a rising edge; holds the request until it is granted
    task automatic drive_a(input logic we, input logic [9:0] adr, input logic [15:0] wd);
        int n = 0;
        a_req_we = we; a_req_adr = adr; a_req_wdata = wd; a_req_valid = 1'b1;
        @(negedge clk);
        while (!a_req_ready && n < 10) begin n++; @(negedge clk); end
        chk("a_granted", 32'(a_req_ready), 1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    task automatic drive_b(input logic we, input logic [9:0] adr, input logic [15:0] wd);
        int n = 0;
        b_req_we = we; b_req_adr = adr; b_req_wdata = wd; b_req_valid = 1'b1;
        @(negedge clk);
        while (!b_req_ready && n < 10) begin n++; @(negedge clk); end
        chk("b_granted", 32'(b_req_ready), 1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int sa, sb, sra, srb;
        // Reset with both ports requesting
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_a_ready", 32'(a_req_ready), 0);
            chk("rst_b_ready", 32'(b_req_ready), 0);
            chk("rst_sram_me", 32'(sram_me), 0);
            chk("rst_sram_we", 32'(sram_we), 0);
            chk("rst_a_rsp", {15'h0, a_rsp_valid, a_rsp_rdata}, 0);
            chk("rst_b_rsp", {15'h0, b_rsp_valid, b_rsp_rdata}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant_a", {30'h0, a_req_ready, b_req_ready}, 2);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        drive_b(1'b0, 10'h0, 16'h0);
        idle(2);
        // Single-port write then read, then hold
        drive_a(1'b1, 10'd5, 16'h1234);
        drive_a(1'b0, 10'd5, 16'h0);
        @(negedge clk);
        chk("a_read_5", {15'h0, a_rsp_valid, a_rsp_rdata}, {16'h1, 16'h1234});
        @(negedge clk);
        chk("a_hold_5", {15'h0, a_rsp_valid, a_rsp_rdata}, {16'h0, 16'h1234});
        idle(1);
        // Contention fairness
        drive_a(1'b1, 10'h3FF, 16'hA5A5);
        drive_b(1'b1, 10'h000, 16'h5A5A);
        sa = cnt_ga; sb = cnt_gb; sra = cnt_ra; srb = cnt_rb;
        fork
            repeat (4) drive_a(1'b0, 10'h3FF, 16'h0);
            repeat (4) drive_b(1'b0, 10'h000, 16'h0);
        join
        idle(3);
        chk("fair_a_grants", 32'(cnt_ga - sa), 4);
        chk("fair_b_grants", 32'(cnt_gb - sb), 4);
        chk("fair_a_rsps", 32'(cnt_ra - sra), 4);
        chk("fair_b_rsps", 32'(cnt_rb - srb), 4);
        // Cross-port coherence
        drive_a(1'b1, 10'd7, 16'hBEEF);
        drive_b(1'b0, 10'd7, 16'h0);
        @(negedge clk);
        chk("b_read_7", {15'h0, b_rsp_valid, b_rsp_rdata}, {16'h1, 16'hBEEF});
        idle(1);
        // Same-cycle conflict with prio = 1 after an A grant
        drive_a(1'b1, 10'd9, 16'h1111);
        fork
            drive_a(1'b1, 10'd9, 16'h0F0F);
            drive_b(1'b0, 10'd9, 16'h0);
        join
        idle(1);
        chk("b_old_9", 32'(b_rsp_rdata), 32'h1111);
        drive_b(1'b0, 10'd9, 16'h0);
        @(negedge clk);
        chk("b_new_9", 32'(b_rsp_rdata), 32'h0F0F);
        idle(1);
        // Reset between read grant and its response edge
        a_req_we = 1'b0; a_req_adr = 10'd5; a_req_valid = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_a_rsp", {15'h0, a_rsp_valid, a_rsp_rdata}, 0);
        end
        idle(2);
        chk("qa_empty", 32'(qa.size()), 0);
        chk("qb_empty", 32'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
